seat_grid_controller: RTL
=========================

Name: seat_grid_controller

Overview:
- Parametrised seat-grid overlay for the VGA pixel path: draws a ROWS x COLS grid of seats over an incoming background colour.
- Holds per-seat occupancy state and a cursor that the user moves with button pulses. A select pulse toggles the seat under the cursor, and the cursor seat blinks.
- Sits between the background generator and the VGA output mux. Output is registered (1-cycle latency).

Parameters:
- ROWS, 2, seat rows; row 0 is the top (back) row.
- COLS, 4, seats per row.
- SEAT_W, 45, seat width in pixels.
- SEAT_H, 45, seat height in pixels.
- GAP, 15, pixel gap between adjacent seats, both axes.
- BASE_X, 450, horizontal centre of the grid.
- BASE_Y, 400, grid bottom edge (exclusive).
- BLINK_FRAMES, 15, frames per blink phase.
- C_EMPTY, 12'h840, free-seat colour.
- C_TAKEN, 12'hF00, occupied-seat colour.
- C_CURSOR, 12'hFF0, cursor colour during the blink-on phase.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- bright  in  1  display-area enable
- hCount  in  10  pixel column
- vCount  in  10  pixel row
- background  in  12  underlying pixel colour
- btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle move pulses, already debounced
- btn_sel  in  1  single-cycle pulse; toggles occupancy of the cursor seat
- clr  in  1  single-cycle pulse; clears all occupancy
- rgb  out  12  registered pixel colour
- occupancy  out  ROWS*COLS  bit i = seat i occupied, i = row*COLS+col
- cur_row  out  clog2(ROWS) (min 1)  cursor row
- cur_col  out  clog2(COLS) (min 1)  cursor column

Behaviour:
- Reset: clk is the only clock. While rst=0 at a clk edge, all of the following clear:
  - rgb=0, occupancy=0, cur_row=0, cur_col=0;
  - blink phase=off, frame counter=0, frame-start history=0.
- Geometry, integer arithmetic:
  - GRID_W = COLS*SEAT_W + (COLS-1)*GAP; GRID_H = ROWS*SEAT_H + (ROWS-1)*GAP.
  - X0 = BASE_X - GRID_W/2 (truncating); Y0 = BASE_Y - GRID_H.
  - Seat (r,c) covers the half-open ranges x in [X0 + c*(SEAT_W+GAP), +SEAT_W) and y in [Y0 + r*(SEAT_H+GAP), +SEAT_H).
  - Gap pixels are not seat pixels.
- Pixel path, registered: rgb(t+1) is computed from the inputs at t.
  - If bright=0: 0.
  - Else if the pixel is in the cursor seat and blink=on: C_CURSOR.
  - Else if the pixel is in seat i and occupancy[i]=1: C_TAKEN.
  - Else if the pixel is in any seat: C_EMPTY.
  - Otherwise: background.
- Cursor moves wrap in both axes:
  - btn_right at col COLS-1 goes to col 0; btn_left at col 0 goes to COLS-1.
  - btn_down at row ROWS-1 goes to row 0; btn_up at row 0 goes to ROWS-1.
  - The horizontal and vertical axes update independently in the same cycle.
  - Opposing pulses on one axis in the same cycle: no move on that axis.
- Occupancy:
  - btn_sel toggles the bit at the cursor position held before any same-cycle move.
  - clr takes priority over btn_sel in the same cycle: result all zero.
  - Occupancy updates are visible on rgb from the next cycle.
- Blink:
  - Frame start = the rising edge of (hCount==0 && vCount==0), compared against its value registered the previous cycle. This gives exactly one event per frame regardless of the clk-to-pixel ratio.
  - On each frame start the counter increments. When the counter reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles. After reset, the first toggle (to on) occurs on the BLINK_FRAMES-th frame start.
  - A cursor move, btn_sel or clr does not reset the blink counter.
- Reset mid-frame: rgb becomes 0 on the next edge. Normal output resumes the cycle after rst returns high.

Optional Feature:
- Macro: SEAT_COUNT_EN.
- Defined: adds output `occ_count`, width clog2(ROWS*COLS+1), reset 0. It tracks popcount(occupancy) incrementally:
  - +1 when btn_sel sets a bit; -1 when btn_sel clears a bit;
  - forced to 0 on clr;
  - updated in the same cycle as occupancy.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Defaults (X0=338, Y0=295), bright=1, background=12'h00F:
  - pixel (338,295) gives rgb=12'h840 one cycle later;
  - (382,339) gives 12'h840; (383,295) gives 12'h00F (gap);
  - (398,355), seat 5, gives 12'h840; (338,400) gives 12'h00F.
- btn_sel with cursor (0,0), then pixel (340,300): rgb=12'hF00 and occupancy=8'h01. A second btn_sel gives occupancy=8'h00.
- Cursor (0,0) + btn_left: cur_col=3. Then btn_up: cur_row=1. Then btn_left and btn_right together: cur_col stays 3.
- btn_sel and btn_right in the same cycle at (0,0): occupancy=8'h01, cur_col=1. clr and btn_sel in the same cycle: occupancy=8'h00 (occ_count=0 if SEAT_COUNT_EN).
- BLINK_FRAMES=2, cursor seat free: after 2 frame starts rgb in seat 0 = 12'hFF0; after 4 = 12'h840. hCount/vCount held at (0,0) for 4 clks counts one frame only.
- Assert rst=0 while occupancy=8'hA5, cursor (1,2), blink on: next edge gives rgb=0, occupancy=0, cursor (0,0), blink off. bright=0 at any seat pixel gives rgb=0.

Source files
------------

// File: rtl/seat_grid_controller.sv
// Seat-grid overlay for the VGA pixel path: occupancy, cursor and blink.
// Optional macro SEAT_COUNT_EN adds the occ_count popcount output.
module seat_grid_controller #(
    parameter int          ROWS         = 2,
    parameter int          COLS         = 4,
    parameter int          SEAT_W       = 45,
    parameter int          SEAT_H       = 45,
    parameter int          GAP          = 15,
    parameter int          BASE_X       = 450,
    parameter int          BASE_Y       = 400,
    parameter int          BLINK_FRAMES = 15,
    parameter logic [11:0] C_EMPTY      = 12'h840,
    parameter logic [11:0] C_TAKEN      = 12'hF00,
    parameter logic [11:0] C_CURSOR     = 12'hFF0,
    localparam int         NS           = ROWS * COLS,
    localparam int         RW           = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int         CW           = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          bright,
    input  logic [9:0]    hCount,
    input  logic [9:0]    vCount,
    input  logic [11:0]   background,
    input  logic          btn_up,
    input  logic          btn_down,
    input  logic          btn_left,
    input  logic          btn_right,
    input  logic          btn_sel,
    input  logic          clr,
    output logic [11:0]   rgb,
    output logic [NS-1:0] occupancy,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col
`ifdef SEAT_COUNT_EN
    ,
    output logic [$clog2(ROWS*COLS+1)-1:0] occ_count
`endif
);

    localparam int GRID_W = COLS * SEAT_W + (COLS - 1) * GAP;
    localparam int GRID_H = ROWS * SEAT_H + (ROWS - 1) * GAP;
    localparam int X0     = BASE_X - GRID_W / 2;
    localparam int Y0     = BASE_Y - GRID_H;
    localparam int PX     = SEAT_W + GAP;
    localparam int PY     = SEAT_H + GAP;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [11:0]   rgb_q, rgb_d;
    logic [NS-1:0] occ_q, occ_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] fcnt_q, fcnt_d;
    logic          fs_q, fs_d;

    int              hx, vy;
    logic [COLS-1:0] col_hit;
    logic [ROWS-1:0] row_hit;
    logic            in_seat, in_cur, in_taken;
    logic [NS-1:0]   sel_mask;
    logic            frame_start;

    assign hx = 32'(hCount);
    assign vy = 32'(vCount);

    // Per-axis seat membership: half-open pixel ranges, gaps excluded
    always_comb begin
        col_hit = '0;
        row_hit = '0;
        for (int c = 0; c < COLS; c++)
            col_hit[c] = (hx >= X0 + c * PX) && (hx < X0 + c * PX + SEAT_W);
        for (int r = 0; r < ROWS; r++)
            row_hit[r] = (vy >= Y0 + r * PY) && (vy < Y0 + r * PY + SEAT_H);
    end

    // Classify the current pixel and build the cursor-seat mask
    always_comb begin
        in_seat  = 1'b0;
        in_cur   = 1'b0;
        in_taken = 1'b0;
        sel_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                sel_mask[r*COLS+c] = (row_q == RW'(r)) && (col_q == CW'(c));
                if (row_hit[r] && col_hit[c]) begin
                    in_seat = 1'b1;
                    if (occ_q[r*COLS+c])
                        in_taken = 1'b1;
                    if (sel_mask[r*COLS+c])
                        in_cur = 1'b1;
                end
            end
        end
    end

    // Next pixel colour by priority: blank, cursor, taken, free, background
    always_comb begin
        rgb_d = 12'h000;
        if (bright) begin
            if (in_cur && blink_q)
                rgb_d = C_CURSOR;
            else if (in_taken)
                rgb_d = C_TAKEN;
            else if (in_seat)
                rgb_d = C_EMPTY;
            else
                rgb_d = background;
        end
    end

    // Cursor moves wrap; opposing pulses on one axis cancel
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (btn_right && !btn_left)
            col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
        else if (btn_left && !btn_right)
            col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
        if (btn_down && !btn_up)
            row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        else if (btn_up && !btn_down)
            row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
    end

    // Occupancy toggles at the pre-move cursor; clear wins over select
    always_comb begin
        occ_d = occ_q;
        if (clr)
            occ_d = '0;
        else if (btn_sel)
            occ_d = occ_q ^ sel_mask;
    end

    // One frame-start event per rising edge of the (0,0) pixel
    always_comb begin
        fs_d        = (hCount == 10'd0) && (vCount == 10'd0);
        frame_start = fs_d && !fs_q;
        fcnt_d      = fcnt_q;
        blink_d     = blink_q;
        if (frame_start) begin
            if (fcnt_q == BW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                blink_d = ~blink_q;
            end else begin
                fcnt_d = fcnt_q + BW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_q   <= '0;
            occ_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            blink_q <= 1'b0;
            fcnt_q  <= '0;
            fs_q    <= 1'b0;
        end else begin
            rgb_q   <= rgb_d;
            occ_q   <= occ_d;
            row_q   <= row_d;
            col_q   <= col_d;
            blink_q <= blink_d;
            fcnt_q  <= fcnt_d;
            fs_q    <= fs_d;
        end
    end

    assign rgb       = rgb_q;
    assign occupancy = occ_q;
    assign cur_row   = row_q;
    assign cur_col   = col_q;

`ifdef SEAT_COUNT_EN
    localparam int KW = $clog2(ROWS * COLS + 1);

    logic [KW-1:0] cnt_q, cnt_d;

    // Running popcount follows each occupancy change
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (btn_sel) begin
            if (|(occ_q & sel_mask))
                cnt_d = cnt_q - KW'(1);
            else
                cnt_d = cnt_q + KW'(1);
        end
    end

    // Count register, cleared with the rest of the state
    always_ff @(posedge clk) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign occ_count = cnt_q;
`endif

endmodule
